fsm_output_trace_buffer: RTL
============================

Name: fsm_output_trace_buffer

Overview:
Downstream capture stage for the sequential controller benchmarks; it consumes the controller's 11-bit output vector (y1..y11).
- Timestamps every non-zero output vector and queues it in a small FIFO, drained over a valid/ready read port by the test/observation logic.
- Flags runs of consecutive all-zero output cycles, the signature of a payload that suppresses outputs.
- Records sticky overflow when events are lost.

Parameters:
- WIDTH, 11, width of monitored output vector (y1 = bit 0 ... y11 = bit 10)
- DEPTH, 8, FIFO entries (power of two, >= 2)
- TS_W, 8, timestamp counter width
- SILENT_LIMIT, 4, consecutive zero samples that raise silent_alarm (1 .. 2^TS_W-1)

Ports:
- clk  input  1  sampling clock, rising edge (controller updates on falling edge, so y_in is stable at the rising edge)
- rst  input  1  reset, asynchronous, active-high
- en  input  1  sample enable; when low, no capture, no timestamp advance, no silent counting
- clr  input  1  synchronous clear: flush FIFO, clear flags, clear counters
- y_in  input  WIDTH  controller output vector
- rd_ready  input  1  consumer accepts head entry
- rd_valid  output  1  FIFO non-empty
- rd_data  output  TS_W+WIDTH  head entry {timestamp, vector}
- count  output  clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: an event was dropped
- silent_alarm  output  1  SILENT_LIMIT consecutive zero samples seen

Behaviour:
- Reset (async, rst=1): FIFO empty, rd_valid=0, rd_data=0, count=0, overflow=0, silent_alarm=0, timestamp=0, silent counter=0.
- Timestamp: increments by 1 on each clk edge with en=1; wraps 2^TS_W-1 -> 0. The captured value is the pre-increment value (first sample after reset carries ts 0).
- Capture condition: en=1 and y_in != 0. Multi-hot vectors are legal and stored unmodified (e.g. y1+y11 = 11'h401).
- Read handshake: pop occurs when rd_valid && rd_ready. rd_data is first-word-fall-through: it shows the head entry whenever rd_valid=1, and holds its last value when the FIFO is empty.
- Write, not full: push entry; visible at rd_data the cycle after the push if the FIFO was empty (1-cycle latency).
- Write, full, with a pop in the same cycle: push and pop both occur; count unchanged; no overflow.
- Write, full, no pop: entry dropped; overflow set and held until clr or rst.
- Pop on empty: ignored.
- count: updates the same edge as push/pop and always equals pushes minus pops. Pointers wrap modulo DEPTH.
- Silent counter:
  - en=1, y_in=0: increment, saturating at SILENT_LIMIT.
  - en=1, y_in!=0: reset to 0.
  - en=0: hold.
  - silent_alarm = 1 when counter == SILENT_LIMIT (registered; asserts on the edge that reaches the limit).
  - The alarm clears on the edge where a non-zero sample is seen.
- clr=1: highest priority after rst. Empties FIFO, zeroes count, overflow, silent counter, alarm and timestamp. Any push or pop that cycle is discarded.
- rst asserted mid-operation: immediate return to reset values; the partially drained FIFO contents are lost.

Test Plan:
- Reset, en=1, y_in=11'h200 (y10) for one cycle then 0 -> next cycle rd_valid=1, rd_data={8'd0,11'h200}, count=1.
- Push 8 non-zero vectors with rd_ready=0, then a 9th -> count=8, overflow=1; drain 8 pops in order with timestamps 0..7; the 9th vector never appears; overflow stays 1 until clr.
- FIFO full, push and rd_ready=1 in the same cycle -> count stays 8, overflow=0, head advances by one entry.
- y_in=0 with en=1 for 4 cycles (SILENT_LIMIT=4) -> silent_alarm=1 after the 4th edge, not the 3rd; en=0 for 3 cycles keeps it 1; then y_in=11'h001 -> silent_alarm=0 and an entry is queued.
- Timestamp wrap: 256 enabled zero cycles then y_in=11'h004 -> entry timestamp 0; an event on cycle 255 carries 8'hFF.
- Assert rst asynchronously (between edges) with count=3 and overflow=1 -> all outputs 0 immediately; first event after release carries ts 0.

Source files
------------

// File: rtl/fsm_output_trace_buffer_if.sv
// Read port of the trace buffer: first-word-fall-through valid/ready stream of
// {timestamp, output vector} entries.
interface fsm_output_trace_buffer_if #(
  parameter int DW = 19
);
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/fsm_output_trace_buffer.sv
// Captures timestamped non-zero controller output vectors into a FWFT FIFO and
// watches for runs of all-zero outputs and lost events.
module fsm_output_trace_buffer #(
  parameter int WIDTH        = 11,
  parameter int DEPTH        = 8,
  parameter int TS_W         = 8,
  parameter int SILENT_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         y_in,
  fsm_output_trace_buffer_if.master rd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     silent_alarm
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_W + WIDTH;
  localparam logic [TS_W-1:0] LIMIT = TS_W'(SILENT_LIMIT);
  localparam logic [AW:0]     FULL  = (AW+1)'(DEPTH);

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [TS_W-1:0] ts, sil_cnt;
  logic [EW-1:0]   rd_data_p1;
  logic            full, event_in, do_push, do_pop, drop;

  function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] c);
    return (c == LIMIT) ? c : c + 1'b1;
  endfunction

  assign full     = (count == FULL);
  assign event_in = en && (|y_in) && !clr;
  assign do_pop   = rd.rd_valid && rd.rd_ready && !clr;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push  = event_in && (!full || do_pop);
  assign drop     = event_in && full && !do_pop;

  assign rd.rd_valid = (count != '0);
  // When empty, replay whatever was shown on the previous cycle.
  assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : rd_data_p1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ts, y_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      ts           <= '0;
      sil_cnt      <= '0;
      silent_alarm <= 1'b0;
      rd_data_p1   <= '0;
    end else begin
      rd_data_p1 <= rd.rd_data;
      if (clr) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        overflow     <= 1'b0;
        ts           <= '0;
        sil_cnt      <= '0;
        silent_alarm <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (drop) overflow <= 1'b1;
        if (en) begin
          ts <= ts + 1'b1;
          if (|y_in) begin
            sil_cnt      <= '0;
            silent_alarm <= 1'b0;
          end else begin
            sil_cnt      <= sat_inc(sil_cnt);
            silent_alarm <= (sat_inc(sil_cnt) == LIMIT);
          end
        end
      end
    end
  end
endmodule
